// File: rtl/banco_registradores_n.sv
// Parametrised register bank: two combinational read ports, one write port,
// and a full shadow bank that is saved and restored in a single cycle for context swaps.
module banco_registradores_n #(
  parameter int LARGURA = 8,
  parameter int NREG    = 4,
  parameter int BYPASS  = 1,
  localparam int A      = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rw,
  input  logic [A-1:0]       rd,
  input  logic [LARGURA-1:0] dado,
  input  logic [A-1:0]       ra,
  input  logic [A-1:0]       rb,
  input  logic               salva,
  input  logic               restaura,
  output logic [LARGURA-1:0] s_ra,
  output logic [LARGURA-1:0] s_rb,
  output logic               sombra_valida
);

  logic [LARGURA-1:0] banco_q  [NREG];
  logic [LARGURA-1:0] banco_d  [NREG];
  logic [LARGURA-1:0] sombra_q [NREG];
  logic [LARGURA-1:0] sombra_d [NREG];
  logic               valida_q;
  logic               valida_d;
  logic               byp_a;
  logic               byp_b;

  // Order matters: the save reads the pre-edge bank, and the write overrides the restore for rd only.
  always_comb begin
    banco_d  = banco_q;
    sombra_d = sombra_q;
    valida_d = valida_q;
    if (salva) begin
      sombra_d = banco_q;
      valida_d = 1'b1;
    end
    if (restaura && valida_q) begin
      banco_d = sombra_q;
    end
    if (rw) begin
      banco_d[rd] = dado;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      banco_q  <= '{default: '0};
      sombra_q <= '{default: '0};
      valida_q <= 1'b0;
    end else begin
      banco_q  <= banco_d;
      sombra_q <= sombra_d;
      valida_q <= valida_d;
    end
  end

  // Forwarding covers only the write port, never a pending restore.
  assign byp_a = (BYPASS != 0) && rw && (rd == ra);
  assign byp_b = (BYPASS != 0) && rw && (rd == rb);

  assign s_ra          = byp_a ? dado : banco_q[ra];
  assign s_rb          = byp_b ? dado : banco_q[rb];
  assign sombra_valida = valida_q;

endmodule
